spart_echo_ctrl: RTL



---
 rtl/spart_drv_pkg.sv | 22 ++
 rtl/echo_fifo.sv | 70 +++++++
 rtl/spart_echo_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spart_drv_pkg.sv
// Shared state encoding, SPART register addresses and baud divisor helper
// for the SPART echo driver.
package spart_drv_pkg;

   typedef enum logic [2:0] {BRG_LO, BRG_HI, SERVICE, RD, WR} state_t;

   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DB_LO  = 2'b10;
   localparam logic [1:0] ADDR_DB_HI  = 2'b11;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   // Baud doubles per br_cfg step from 4800; callers narrow the result to their divisor width.
   function automatic logic [31:0] baud_div(input int unsigned clk_hz, input logic [1:0] cfg);
      int unsigned baud;
      baud = 32'd4800 << cfg;
      return clk_hz / (32'd16 * baud) - 32'd1;
   endfunction

endpackage

// File: rtl/echo_fifo.sv
// Byte FIFO holding received characters until the transmitter can echo them.
// Pushes into a full FIFO are ignored; pointers wrap modulo DEPTH (power of 2).
module echo_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [7:0]                 din,
   input  logic                       pop,
   output logic [7:0]                 dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   always_comb begin
      full     = (level_q == LW'(DEPTH));
      empty    = (level_q == '0);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign level = level_q;

endmodule

// File: rtl/spart_echo_ctrl.sv
// Programs the SPART baud divisor from br_cfg, then echoes received bytes via a FIFO.
// Optional macro ECHO_CRLF_EN: follow every echoed 0x0D with an extra 0x0A.
module spart_echo_ctrl
   import spart_drv_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50000000,
   parameter int          DEPTH       = 8,
   parameter int          DIV_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 br_cfg,
   input  logic                       rda,
   input  logic                       tbr,
   output logic                       iocs,
   output logic                       iorw,
   output logic [1:0]                 ioaddr,
   inout  wire  [7:0]                 databus,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic                       overrun,
   output logic                       cfg_done
);

   localparam logic [DIV_W-1:0] DIV_0 = DIV_W'(baud_div(CLK_FREQ_HZ, 2'd0));
   localparam logic [DIV_W-1:0] DIV_1 = DIV_W'(baud_div(CLK_FREQ_HZ, 2'd1));
   localparam logic [DIV_W-1:0] DIV_2 = DIV_W'(baud_div(CLK_FREQ_HZ, 2'd2));
   localparam logic [DIV_W-1:0] DIV_3 = DIV_W'(baud_div(CLK_FREQ_HZ, 2'd3));

   state_t      state_q, state_d;
   logic [1:0]  br_cfg_q, br_cfg_d;
   logic        cfg_done_q, cfg_done_d;
   logic        overrun_q, overrun_d;
   logic        last_wr_q, last_wr_d;
`ifdef ECHO_CRLF_EN
   logic        crlf_pend_q, crlf_pend_d;
   logic        wr_crlf_q, wr_crlf_d;
`endif

   logic [15:0] bus_div;
   logic        bus_cs, bus_rd, bus_drive;
   logic [1:0]  bus_addr;
   logic [7:0]  bus_wdata;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_dout;
   logic        rd_ok, wr_ok;

   echo_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (databus),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      case (br_cfg_q)
         2'd0:    bus_div = 16'(DIV_0);
         2'd1:    bus_div = 16'(DIV_1);
         2'd2:    bus_div = 16'(DIV_2);
         default: bus_div = 16'(DIV_3);
      endcase
   end

   always_comb begin
      state_d    = state_q;
      br_cfg_d   = br_cfg_q;
      cfg_done_d = cfg_done_q;
      overrun_d  = overrun_q;
      last_wr_d  = last_wr_q;
`ifdef ECHO_CRLF_EN
      crlf_pend_d = crlf_pend_q;
      wr_crlf_d   = wr_crlf_q;
`endif
      bus_cs     = 1'b0;
      bus_rd     = 1'b1;
      bus_addr   = ADDR_DATA;
      bus_drive  = 1'b0;
      bus_wdata  = 8'h00;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      rd_ok      = rda;
      wr_ok      = tbr && !fifo_empty;
      case (state_q)
         BRG_LO: begin
            bus_cs    = 1'b1;
            bus_rd    = 1'b0;
            bus_addr  = ADDR_DB_LO;
            bus_drive = 1'b1;
            bus_wdata = bus_div[7:0];
            state_d   = BRG_HI;
         end
         BRG_HI: begin
            bus_cs     = 1'b1;
            bus_rd     = 1'b0;
            bus_addr   = ADDR_DB_HI;
            bus_drive  = 1'b1;
            bus_wdata  = bus_div[15:8];
            cfg_done_d = 1'b1;
            state_d    = SERVICE;
         end
         SERVICE: begin
            // A pending reprogram beats any echo traffic; otherwise alternate RD/WR under contention.
            if (br_cfg != br_cfg_q) begin
               br_cfg_d   = br_cfg;
               cfg_done_d = 1'b0;
               state_d    = BRG_LO;
            end
`ifdef ECHO_CRLF_EN
            else if (crlf_pend_q && tbr) begin
               wr_crlf_d = 1'b1;
               last_wr_d = 1'b1;
               state_d   = WR;
            end
`endif
            else if (rd_ok && (!wr_ok || last_wr_q)) begin
               last_wr_d = 1'b0;
               state_d   = RD;
            end else if (wr_ok) begin
`ifdef ECHO_CRLF_EN
               wr_crlf_d = 1'b0;
`endif
               last_wr_d = 1'b1;
               state_d   = WR;
            end
         end
         RD: begin
            bus_cs    = 1'b1;
            bus_rd    = 1'b1;
            fifo_push = !fifo_full;
            if (fifo_full) begin
               overrun_d = 1'b1;
            end
            state_d   = SERVICE;
         end
         WR: begin
            bus_cs    = 1'b1;
            bus_rd    = 1'b0;
            bus_drive = 1'b1;
            state_d   = SERVICE;
`ifdef ECHO_CRLF_EN
            if (wr_crlf_q) begin
               bus_wdata   = CHAR_LF;
               crlf_pend_d = 1'b0;
            end else begin
               bus_wdata   = fifo_dout;
               fifo_pop    = 1'b1;
               crlf_pend_d = (fifo_dout == CHAR_CR);
            end
`else
            bus_wdata = fifo_dout;
            fifo_pop  = 1'b1;
`endif
         end
         default: state_d = BRG_LO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BRG_LO;
         br_cfg_q   <= br_cfg;
         cfg_done_q <= 1'b0;
         overrun_q  <= 1'b0;
         last_wr_q  <= 1'b1;
`ifdef ECHO_CRLF_EN
         crlf_pend_q <= 1'b0;
         wr_crlf_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         br_cfg_q   <= br_cfg_d;
         cfg_done_q <= cfg_done_d;
         overrun_q  <= overrun_d;
         last_wr_q  <= last_wr_d;
`ifdef ECHO_CRLF_EN
         crlf_pend_q <= crlf_pend_d;
         wr_crlf_q   <= wr_crlf_d;
`endif
      end
   end

   // Reset idles the bus combinationally so the databus is released in the reset cycle itself.
   assign iocs     = bus_cs & ~rst;
   assign iorw     = bus_rd | rst;
   assign ioaddr   = rst ? ADDR_DATA : bus_addr;
   assign databus  = (bus_drive && !rst) ? bus_wdata : 8'hzz;
   assign overrun  = overrun_q;
   assign cfg_done = cfg_done_q;

endmodule
